// File: rtl/instruction_queue_if.sv
// Interface bundling the control-unit push port, the dispatch pop port and the
// queue status lines for instruction_queue.
interface instruction_queue_if #(
  parameter int unsigned LOG_DEPTH = 3,
  parameter int unsigned ADDR_W    = 18
);
  // Push side (control unit)
  logic              queue_we;
  logic [1:0]        queue_instr_type;
  logic [15:0]       queue_instr;
  logic [ADDR_W-1:0] cache_addr;
  logic [ADDR_W-1:0] main_mem_addr;
  logic [ADDR_W-1:0] d_cache_addr;
  logic [ADDR_W-1:0] d_main_mem_addr;
  logic              full;
  logic              almost_full;

  // Pop side (dispatch)
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_instr_type;
  logic [15:0]       out_instr;
  logic [ADDR_W-1:0] out_cache_addr;
  logic [ADDR_W-1:0] out_main_mem_addr;
  logic [ADDR_W-1:0] out_d_cache_addr;
  logic [ADDR_W-1:0] out_d_main_mem_addr;

  // Status
  logic [LOG_DEPTH:0] count;
  logic               overflow;

  modport master (
    output queue_we, queue_instr_type, queue_instr,
    output cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr,
    output out_ready,
    input  full, almost_full, out_valid,
    input  out_instr_type, out_instr,
    input  out_cache_addr, out_main_mem_addr, out_d_cache_addr, out_d_main_mem_addr,
    input  count, overflow
  );

  modport slave (
    input  queue_we, queue_instr_type, queue_instr,
    input  cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr,
    input  out_ready,
    output full, almost_full, out_valid,
    output out_instr_type, out_instr,
    output out_cache_addr, out_main_mem_addr, out_d_cache_addr, out_d_main_mem_addr,
    output count, overflow
  );
endinterface

// File: rtl/instruction_queue.sv
// In-order decoupling FIFO between the control unit and the execution units,
// with full/almost-full back-pressure and a sticky overflow flag.
module instruction_queue #(
  parameter int unsigned LOG_DEPTH    = 3,
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned AFULL_THRESH = 6
) (
  input logic               clk,
  input logic               reset,
  instruction_queue_if.slave q
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DepthCnt = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] AfullCnt = (LOG_DEPTH + 1)'(AFULL_THRESH);

  typedef struct packed {
    logic [1:0]        instr_type;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] cache_addr;
    logic [ADDR_W-1:0] main_mem_addr;
    logic [ADDR_W-1:0] d_cache_addr;
    logic [ADDR_W-1:0] d_main_mem_addr;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic   full;
  logic   valid;
  logic   push;
  logic   pop;
  logic   push_rejected;
  entry_t entry_in;
  entry_t head;

  assign full  = (count_q == DepthCnt);
  assign valid = (count_q != '0);

  // Full gates the push even when a pop frees a slot in the same cycle;
  // reset masks both sides so a mid-stream reset leaves nothing behind.
  assign push          = q.queue_we && !full && !reset;
  assign pop           = valid && q.out_ready && !reset;
  assign push_rejected = q.queue_we && full;

  always_comb begin
    entry_in                 = '0;
    entry_in.instr_type      = q.queue_instr_type;
    entry_in.instr           = q.queue_instr;
    entry_in.cache_addr      = q.cache_addr;
    entry_in.main_mem_addr   = q.main_mem_addr;
    entry_in.d_cache_addr    = q.d_cache_addr;
    entry_in.d_main_mem_addr = q.d_main_mem_addr;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push_rejected) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign q.full                = full;
  assign q.almost_full         = (count_q >= AfullCnt);
  assign q.out_valid           = valid;
  assign q.out_instr_type      = head.instr_type;
  assign q.out_instr           = head.instr;
  assign q.out_cache_addr      = head.cache_addr;
  assign q.out_main_mem_addr   = head.main_mem_addr;
  assign q.out_d_cache_addr    = head.d_cache_addr;
  assign q.out_d_main_mem_addr = head.d_main_mem_addr;
  assign q.count               = count_q;
  assign q.overflow            = overflow_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue: reset, latency, fill and
// overflow, wrap-around, simultaneous push/pop corner cases and mid-stream reset.
module tb_instruction_queue;

  localparam int unsigned LOG_DEPTH = 3;
  localparam int unsigned ADDR_W    = 18;
  localparam logic [1:0]  INSTR_TYPE_RAM = 2'd1;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  instruction_queue_if #(.LOG_DEPTH(LOG_DEPTH), .ADDR_W(ADDR_W)) iq ();

  instruction_queue #(
    .LOG_DEPTH   (LOG_DEPTH),
    .ADDR_W      (ADDR_W),
    .AFULL_THRESH(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .q    (iq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iq.queue_we  = 1'b0;
    iq.out_ready = 1'b0;
  endtask

  // Fields other than cache_addr are derived from it so any mix-up shows.
  task automatic set_push(input int c);
    iq.queue_we         = 1'b1;
    iq.queue_instr_type = 2'(c);
    iq.queue_instr      = 16'(16'h1000 + c);
    iq.cache_addr       = ADDR_W'(c);
    iq.main_mem_addr    = ADDR_W'(c + 100);
    iq.d_cache_addr     = ADDR_W'(c + 200);
    iq.d_main_mem_addr  = ADDR_W'(c + 300);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push_n(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      set_push(first + i);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    set_push(0);
    iq.queue_we = 1'b0;
    step();
    step();
    reset = 1'b0;
    checks++; if (iq.count !== 4'd0) $display("FAIL reset_count: got %0d want 0", iq.count); else passed++;
    checks++; if (iq.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", iq.out_valid); else passed++;
    checks++; if (iq.full !== 1'b0) $display("FAIL reset_full: got %b want 0", iq.full); else passed++;
    checks++; if (iq.almost_full !== 1'b0) $display("FAIL reset_afull: got %b want 0", iq.almost_full); else passed++;
    checks++; if (iq.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", iq.overflow); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    iq.queue_we         = 1'b1;
    iq.queue_instr_type = INSTR_TYPE_RAM;
    iq.queue_instr      = 16'h4A00;
    iq.cache_addr       = '0;
    iq.main_mem_addr    = 18'd3;
    iq.d_cache_addr     = '0;
    iq.d_main_mem_addr  = '0;
    iq.out_ready        = 1'b0;
    step();
    idle();
    checks++; if (iq.out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", iq.out_valid); else passed++;
    checks++; if (iq.count !== 4'd1) $display("FAIL single_count: got %0d want 1", iq.count); else passed++;
    checks++; if (iq.out_main_mem_addr !== 18'd3) $display("FAIL single_mm_addr: got %0d want 3", iq.out_main_mem_addr); else passed++;
    checks++; if (iq.out_instr !== 16'h4A00) $display("FAIL single_instr: got %h want 4a00", iq.out_instr); else passed++;
    checks++; if (iq.out_instr_type !== INSTR_TYPE_RAM) $display("FAIL single_type: got %0d want %0d", iq.out_instr_type, INSTR_TYPE_RAM); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (iq.out_valid !== 1'b1 || iq.out_instr !== 16'h4A00 || iq.out_main_mem_addr !== 18'd3 ||
          iq.count !== 4'd1)
        $display("FAIL single_hold%0d: got valid=%b instr=%h mm=%0d count=%0d want 1/4a00/3/1",
                 i, iq.out_valid, iq.out_instr, iq.out_main_mem_addr, iq.count);
      else passed++;
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_push(i);
      step();
      checks++;
      if (iq.almost_full !== (i >= 5) || iq.full !== (i == 7))
        $display("FAIL fill_flags%0d: got afull=%b full=%b want %b/%b",
                 i, iq.almost_full, iq.full, (i >= 5), (i == 7));
      else passed++;
    end
    checks++; if (iq.count !== 4'd8) $display("FAIL fill_count: got %0d want 8", iq.count); else passed++;
    set_push(99);
    step();
    idle();
    checks++; if (iq.overflow !== 1'b1) $display("FAIL fill_overflow: got %b want 1", iq.overflow); else passed++;
    checks++; if (iq.count !== 4'd8) $display("FAIL fill_count_after_ovf: got %0d want 8", iq.count); else passed++;
    iq.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (iq.out_valid !== 1'b1 || iq.out_cache_addr !== ADDR_W'(i))
        $display("FAIL drain%0d: got valid=%b cache=%0d want 1/%0d", i, iq.out_valid, iq.out_cache_addr, i);
      else passed++;
      step();
    end
    idle();
    checks++; if (iq.out_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", iq.out_valid); else passed++;
    checks++; if (iq.overflow !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", iq.overflow); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    push_n(0, 5);
    iq.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    idle();
    checks++; if (iq.count !== 4'd0) $display("FAIL wrap_empty: got %0d want 0", iq.count); else passed++;
    push_n(10, 6);
    checks++; if (iq.count !== 4'd6) $display("FAIL wrap_count: got %0d want 6", iq.count); else passed++;
    iq.out_ready = 1'b1;
    for (int c = 10; c < 16; c++) begin
      checks++;
      if (iq.out_valid !== 1'b1 || iq.out_cache_addr !== ADDR_W'(c) ||
          iq.out_main_mem_addr !== ADDR_W'(c + 100) || iq.out_d_cache_addr !== ADDR_W'(c + 200) ||
          iq.out_d_main_mem_addr !== ADDR_W'(c + 300) || iq.out_instr !== 16'(16'h1000 + c))
        $display("FAIL wrap_pop%0d: got valid=%b cache=%0d mm=%0d dc=%0d dmm=%0d instr=%h",
                 c, iq.out_valid, iq.out_cache_addr, iq.out_main_mem_addr,
                 iq.out_d_cache_addr, iq.out_d_main_mem_addr, iq.out_instr);
      else passed++;
      step();
    end
    idle();
    checks++; if (iq.count !== 4'd0) $display("FAIL wrap_final_count: got %0d want 0", iq.count); else passed++;
  endtask

  task automatic test_full_simul();
    do_reset();
    push_n(0, 8);
    set_push(77);
    iq.out_ready = 1'b1;
    step();
    idle();
    checks++; if (iq.count !== 4'd7) $display("FAIL fullsim_count: got %0d want 7", iq.count); else passed++;
    checks++; if (iq.overflow !== 1'b1) $display("FAIL fullsim_overflow: got %b want 1", iq.overflow); else passed++;
    checks++; if (iq.out_cache_addr !== 18'd1) $display("FAIL fullsim_head: got %0d want 1", iq.out_cache_addr); else passed++;
    iq.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (iq.out_valid !== 1'b1 || iq.out_cache_addr !== ADDR_W'(i))
        $display("FAIL fullsim_drain%0d: got valid=%b cache=%0d want 1/%0d", i, iq.out_valid, iq.out_cache_addr, i);
      else passed++;
      step();
    end
    idle();
    checks++; if (iq.out_valid !== 1'b0) $display("FAIL fullsim_empty: got %b want 0", iq.out_valid); else passed++;
  endtask

  task automatic test_count_one();
    do_reset();
    push_n(1, 1);
    set_push(2);
    iq.out_ready = 1'b1;
    step();
    idle();
    checks++; if (iq.count !== 4'd1) $display("FAIL one_count: got %0d want 1", iq.count); else passed++;
    checks++; if (iq.out_valid !== 1'b1) $display("FAIL one_valid: got %b want 1", iq.out_valid); else passed++;
    checks++; if (iq.out_cache_addr !== 18'd2) $display("FAIL one_head: got %0d want 2", iq.out_cache_addr); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_n(0, 9);  // ninth push overflows
    iq.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    idle();
    checks++; if (iq.count !== 4'd4 || iq.overflow !== 1'b1) $display("FAIL mid_setup: got count=%0d ovf=%b want 4/1", iq.count, iq.overflow); else passed++;
    set_push(50);
    iq.out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    checks++; if (iq.count !== 4'd0) $display("FAIL mid_count: got %0d want 0", iq.count); else passed++;
    checks++; if (iq.out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", iq.out_valid); else passed++;
    checks++; if (iq.full !== 1'b0) $display("FAIL mid_full: got %b want 0", iq.full); else passed++;
    checks++; if (iq.overflow !== 1'b0) $display("FAIL mid_overflow: got %b want 0", iq.overflow); else passed++;
    push_n(5, 1);
    checks++; if (iq.out_valid !== 1'b1 || iq.out_cache_addr !== 18'd5) $display("FAIL mid_push: got valid=%b cache=%0d want 1/5", iq.out_valid, iq.out_cache_addr); else passed++;
    checks++; if (iq.count !== 4'd1) $display("FAIL mid_push_count: got %0d want 1", iq.count); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    idle();
    set_push(0);
    iq.queue_we = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_wrap();
    test_full_simul();
    test_count_one();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Decoupling FIFO between the control unit and the execution units.
- Captures each entry the control unit writes with queue_we: instruction type, raw instruction word, and the four APU-computed addresses.
- Presents entries in order to downstream dispatch through a valid/ready handshake.
- Provides full and almost-full back-pressure so the control unit holds in its insert-to-queue state instead of losing entries.

Parameters:
- LOG_DEPTH, 3, log2 of entry count; DEPTH = 2**LOG_DEPTH (default 8 entries).
- ADDR_W, 18, width of each of the four address fields.
- AFULL_THRESH, 6, occupancy at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- queue_we  in  1  push request from control unit.
- queue_instr_type  in  2  instruction type (INSTR_TYPE_* encoding).
- queue_instr  in  16  raw instruction word.
- cache_addr  in  ADDR_W  cache address for the entry.
- main_mem_addr  in  ADDR_W  main-memory address for the entry.
- d_cache_addr  in  ADDR_W  cache address stride (delta) for the entry.
- d_main_mem_addr  in  ADDR_W  main-memory address stride (delta) for the entry.
- full  out  1  occupancy == DEPTH.
- almost_full  out  1  occupancy >= AFULL_THRESH.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts head this cycle.
- out_instr_type  out  2  head type.
- out_instr  out  16  head instruction.
- out_cache_addr, out_main_mem_addr, out_d_cache_addr, out_d_main_mem_addr  out  ADDR_W each  head addresses.
- count  out  LOG_DEPTH+1  current occupancy.
- overflow  out  1  sticky: a push was attempted while full.

Behaviour:
- Storage: DEPTH-entry register array, entry = {type, instr, 4 addresses} = 90 bits at default widths.
- Pointers: wr_ptr and rd_ptr are LOG_DEPTH bits and wrap modulo DEPTH; count is tracked separately.
- Push accepted = queue_we && !full, evaluated on the pre-edge state. On accept, write the entry at wr_ptr and increment wr_ptr.
- Pop accepted = out_valid && out_ready. On accept, increment rd_ptr.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Simultaneous push and pop when full: push rejected (full gates push even with a same-cycle pop), pop proceeds, overflow sets, count becomes DEPTH-1.
- Simultaneous push and pop when count == 1: both happen; head advances to the new entry, which is valid next cycle.
- Push while full: data dropped, pointers unchanged, overflow <= 1. overflow clears only on reset.
- out_valid = (count != 0). Head fields are read combinationally from array[rd_ptr]. Result: an entry pushed at edge N into an empty queue is visible with out_valid=1 after edge N (1-cycle latency).
- Head field values are don't-care while out_valid=0; the bench must not check them.
- out_ready while out_valid=0: ignored, no state change.
- full and almost_full are combinational from count; they hold for the whole cycle and change only after an edge.
- Handshake: the consumer may hold out_ready low indefinitely; head fields stay stable while out_valid=1 and no pop occurs.
- Reset (synchronous, including mid-stream):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - full=0, almost_full=0, out_valid=0.
  - Array contents are not cleared, and any push or pop in the reset cycle is ignored.
- No internal state machine beyond pointer/count registers; ordering is strictly FIFO, no type-based reordering.

Test Plan:
- Reset, then push one RAM entry (type=INSTR_TYPE_RAM, instr=16'h4A00, main_mem_addr=3, cache_addr=0), out_ready=0 → after one edge: out_valid=1, count=1, out_main_mem_addr=3, out_instr=16'h4A00; fields stay stable for 3 further cycles.
- Push 8 entries with cache_addr=0..7, no pops → after the 6th push almost_full=1; after the 8th full=1, count=8. A 9th push (cache_addr=99) → overflow=1, count stays 8. Draining with out_ready=1 yields cache_addr 0..7 in order, then out_valid=0.
- Wrap-around: push 5, pop 5, then push 6 with cache_addr=10..15 → pointers wrap past index 7; pops return 10..15 in order, count returns to 0.
- Full with simultaneous queue_we and out_ready → count becomes 7, head advances by one, overflow=1, and the rejected data never appears at the output.
- count=1 with simultaneous push (cache_addr=2) and pop → count stays 1, next head out_cache_addr=2.
- Assert reset with 4 entries queued and push+pop active → next cycle count=0, out_valid=0, full=0, overflow=0; a subsequent push of cache_addr=5 appears as the head.
